// File: rtl/seq_signed_mult_display.sv
// rtl/seq_signed_mult_display.sv - signed shift-add multiplier with double-dabble BCD and scrolling 7-seg readout
module seq_signed_mult_display #(
    parameter int W            = 8,
    parameter int ND           = 5,
    parameter int DIGITS_SHOWN = 3,
    parameter int REFRESH_DIV  = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    scroll_left,
    input  logic                    scroll_right,
    input  logic [W-1:0]            multiplier,
    input  logic [W-1:0]            multiplicand,
    output logic                    busy,
    output logic                    done,
    output logic [2*W-1:0]          product,
    output logic [6:0]              segments,
    output logic [DIGITS_SHOWN:0]   anode_active
);

    localparam int M      = 2 * W - 1;
    localparam int CW     = $clog2(M + 1);
    localparam int MAXOFF = ND - DIGITS_SHOWN;
    localparam int OW     = (MAXOFF > 0) ? $clog2(MAXOFF + 1) : 1;
    localparam int SW     = $clog2(DIGITS_SHOWN + 1);
    localparam int RW     = $clog2(REFRESH_DIV + 1);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_CONV, S_FIN} state_t;

    state_t              state, state_next;
    logic [CW-1:0]       cnt;
    logic [M-1:0]        a_sh;
    logic [W-1:0]        b_sh;
    logic [M-1:0]        acc;
    logic [M-1:0]        acc_next;
    logic                neg;
    logic [M-1:0]        dd_bin;
    logic [4*ND-1:0]     dd_bcd;
    logic [4*ND-1:0]     dd_adj;
    logic [4*ND-1:0]     bcd_q;
    logic [4*ND-1:0]     bcd_next;
    logic                sign_neg;
    logic                sign_next;
    logic [W-1:0]        mag_a;
    logic [W-1:0]        mag_b;
    logic [2*W-1:0]      mag_ext;
    logic [2*W-1:0]      prod_fin;
    logic                start_accept;

    logic [OW-1:0]       off, off_next;
    logic [RW-1:0]       rcnt, rcnt_next;
    logic [SW-1:0]       slot, slot_next;
    logic [3:0]          dig;
    int                  idx;
    logic [6:0]          seg_next;
    logic [DIGITS_SHOWN:0] anode_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    assign start_accept = start && (state == S_IDLE);
    assign mag_a = multiplicand[W-1] ? (~multiplicand + W'(1)) : multiplicand;
    assign mag_b = multiplier[W-1]   ? (~multiplier + W'(1))   : multiplier;
    assign acc_next = acc + (b_sh[0] ? a_sh : '0);
    assign mag_ext  = {1'b0, acc};
    assign prod_fin = neg ? (~mag_ext + (2*W)'(1)) : mag_ext;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_MULT;
            S_MULT: if (cnt == CW'(W - 1)) state_next = S_CONV;
            S_CONV: if (cnt == CW'(M - 1)) state_next = S_FIN;
            S_FIN:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // add-3 correction applied to every digit before each dabble shift
    always_comb begin
        dd_adj = dd_bcd;
        for (int i = 0; i < ND; i++) begin
            if (dd_adj[4*i +: 4] >= 4'd5) dd_adj[4*i +: 4] = dd_adj[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            neg      <= 1'b0;
            dd_bin   <= '0;
            dd_bcd   <= '0;
            product  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= (state_next != S_IDLE);
            done <= (state == S_FIN);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh <= {{(M-W){1'b0}}, mag_a};
                        b_sh <= mag_b;
                        acc  <= '0;
                        neg  <= multiplier[W-1] ^ multiplicand[W-1];
                        cnt  <= '0;
                    end
                end
                S_MULT: begin
                    acc  <= acc_next;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    if (cnt == CW'(W - 1)) begin
                        cnt    <= '0;
                        dd_bin <= acc_next;
                        dd_bcd <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_CONV: begin
                    dd_bcd <= {dd_adj[4*ND-2:0], dd_bin[M-1]};
                    dd_bin <= {dd_bin[M-2:0], 1'b0};
                    cnt    <= cnt + CW'(1);
                end
                S_FIN: product <= prod_fin;
                default: ;
            endcase
        end
    end

    // display pipeline registers the decode of next-state values so that
    // commits and scrolls appear on the same edge that makes them
    always_comb begin
        bcd_next  = (state == S_FIN) ? dd_bcd : bcd_q;
        sign_next = (state == S_FIN) ? (neg && (acc != '0)) : sign_neg;

        off_next = off;
        if (start_accept) off_next = '0;
        else if (scroll_right && !scroll_left && (off < OW'(MAXOFF))) off_next = off + OW'(1);
        else if (scroll_left && !scroll_right && (off != '0)) off_next = off - OW'(1);

        rcnt_next = rcnt + RW'(1);
        slot_next = slot;
        if (rcnt == RW'(REFRESH_DIV - 1)) begin
            rcnt_next = '0;
            slot_next = (slot == SW'(DIGITS_SHOWN)) ? '0 : slot + SW'(1);
        end

        idx = MAXOFF - int'(off_next) + int'(slot_next);
        dig = 4'd0;
        for (int i = 0; i < ND; i++) begin
            if (i == idx) dig = bcd_next[4*i +: 4];
        end

        if (slot_next == SW'(DIGITS_SHOWN)) seg_next = sign_next ? 7'b1111110 : 7'b1111111;
        else                                seg_next = seg_decode(dig);
        anode_next = ~((DIGITS_SHOWN+1)'(1) << slot_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q        <= '0;
            sign_neg     <= 1'b0;
            off          <= '0;
            rcnt         <= '0;
            slot         <= '0;
            segments     <= 7'b0000001;
            anode_active <= ~((DIGITS_SHOWN+1)'(1));
        end else begin
            bcd_q        <= bcd_next;
            sign_neg     <= sign_next;
            off          <= off_next;
            rcnt         <= rcnt_next;
            slot         <= slot_next;
            segments     <= seg_next;
            anode_active <= anode_next;
        end
    end

endmodule

// File: tb/tb_seq_signed_mult_display.sv
// tb/tb_seq_signed_mult_display.sv - directed self-checking bench for seq_signed_mult_display
module tb_seq_signed_mult_display;

    localparam logic [6:0] S0    = 7'b0000001;
    localparam logic [6:0] S1    = 7'b1001111;
    localparam logic [6:0] S3    = 7'b0000110;
    localparam logic [6:0] S5    = 7'b0100100;
    localparam logic [6:0] S6    = 7'b0100000;
    localparam logic [6:0] MINUS = 7'b1111110;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        scroll_left = 1'b0;
    logic        scroll_right = 1'b0;
    logic [7:0]  multiplier = 8'd0;
    logic [7:0]  multiplicand = 8'd0;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [6:0]  segments;
    logic [3:0]  anode_active;

    int checks = 0;
    int failures = 0;

    seq_signed_mult_display #(
        .W(8), .ND(5), .DIGITS_SHOWN(3), .REFRESH_DIV(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .scroll_left(scroll_left), .scroll_right(scroll_right),
        .multiplier(multiplier), .multiplicand(multiplicand),
        .busy(busy), .done(done), .product(product),
        .segments(segments), .anode_active(anode_active)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_mult(input logic [7:0] a, input logic [7:0] b);
        multiplier = a;
        multiplicand = b;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    task automatic wait_done(input int already, output int lat);
        lat = already;
        while (!done && lat < 60) begin
            step;
            lat++;
        end
    endtask

    task automatic pulse_scroll(input logic l, input logic r);
        scroll_left = l;
        scroll_right = r;
        step;
        scroll_left = 1'b0;
        scroll_right = 1'b0;
    endtask

    task automatic check_window(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                                input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] exp;
        logic       ok;
        for (int i = 0; i < 8; i++) begin
            step;
            ok = 1'b1;
            case (anode_active)
                4'b1110: exp = e0;
                4'b1101: exp = e1;
                4'b1011: exp = e2;
                4'b0111: exp = e3;
                default: begin ok = 1'b0; exp = 7'h7f; end
            endcase
            chk({tag, "_anode"}, {31'd0, ok}, 32'd1);
            chk({tag, "_seg"}, {25'd0, segments}, {25'd0, exp});
        end
    endtask

    initial begin
        int lat;
        int dones;
        int done_at;
        int busy_bad;

        step;
        step;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_product", {16'd0, product}, 32'd0);
        chk("rst_anode", {28'd0, anode_active}, 32'hE);
        chk("rst_seg", {25'd0, segments}, {25'd0, S0});
        rst = 1'b0;

        start_mult(8'h80, 8'h80);
        chk("m128_busy_start", {31'd0, busy}, 32'd1);
        wait_done(0, lat);
        chk("m128_latency", lat, 32'd24);
        chk("m128_busy_at_done", {31'd0, busy}, 32'd0);
        chk("m128_product", {16'd0, product}, 32'd16384);
        step;
        chk("m128_done_pulse", {31'd0, done}, 32'd0);
        check_window("m128_win", S3, S6, S1, BLANK);

        start_mult(8'd5, 8'hFD);
        wait_done(0, lat);
        chk("m15_latency", lat, 32'd24);
        chk("m15_product", {16'd0, product}, 32'h0000FFF1);
        check_window("m15_off0", S0, S0, S0, MINUS);
        pulse_scroll(1'b0, 1'b1);
        pulse_scroll(1'b0, 1'b1);
        check_window("m15_off2", S5, S1, S0, MINUS);
        pulse_scroll(1'b0, 1'b1);
        check_window("m15_sat_right", S5, S1, S0, MINUS);
        pulse_scroll(1'b1, 1'b0);
        pulse_scroll(1'b1, 1'b0);
        pulse_scroll(1'b1, 1'b0);
        check_window("m15_sat_left", S0, S0, S0, MINUS);
        pulse_scroll(1'b0, 1'b1);
        check_window("m15_off1", S1, S0, S0, MINUS);
        pulse_scroll(1'b1, 1'b1);
        check_window("m15_both", S1, S0, S0, MINUS);

        scroll_right = 1'b1;
        start_mult(8'd0, 8'hF9);
        scroll_right = 1'b0;
        check_window("zero_busy_hold", S0, S0, S0, MINUS);
        wait_done(8, lat);
        chk("zero_latency", lat, 32'd24);
        chk("zero_product", {16'd0, product}, 32'd0);
        check_window("zero_win", S0, S0, S0, BLANK);

        start_mult(8'd3, 8'd4);
        dones = 0;
        done_at = 0;
        busy_bad = 0;
        for (int n = 1; n <= 30; n++) begin
            if (n == 5) begin
                multiplier = 8'd7;
                multiplicand = 8'd7;
                start = 1'b1;
            end
            step;
            start = 1'b0;
            if (done) begin
                dones++;
                done_at = n;
            end
            if ((n < 24) != busy) busy_bad++;
        end
        chk("restart_done_count", dones, 32'd1);
        chk("restart_done_at", done_at, 32'd24);
        chk("restart_product", {16'd0, product}, 32'd12);
        chk("restart_busy_shape", busy_bad, 32'd0);

        start_mult(8'd9, 8'd9);
        for (int n = 1; n <= 14; n++) step;
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_product", {16'd0, product}, 32'd0);
        chk("abort_anode", {28'd0, anode_active}, 32'hE);
        chk("abort_seg", {25'd0, segments}, {25'd0, S0});
        dones = 0;
        for (int n = 0; n < 12; n++) begin
            step;
            if (done || busy) dones++;
        end
        chk("abort_stays_idle", dones, 32'd0);

        start_mult(8'hFE, 8'd3);
        wait_done(0, lat);
        chk("m6_latency", lat, 32'd24);
        chk("m6_product", {16'd0, product}, 32'h0000FFFA);
        check_window("m6_win", S0, S0, S0, MINUS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
